// File: rtl/mix_io_pkg.sv
// Shared definitions for the MIX block-I/O engine: op codes, FSM states, byte/word geometry.
package mix_io_pkg;

  localparam int BYTES_PER_WORD = 5;
  localparam int BYTE_W         = 6;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int MIX_W          = WORD_W + 1;

  typedef enum logic [1:0] {
    IO_IN  = 2'd0,
    IO_OUT = 2'd1,
    IO_IOC = 2'd2,
    IO_RSV = 2'd3
  } io_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IN_BYTE  = 3'd1,
    S_IN_WR    = 3'd2,
    S_OUT_RD   = 3'd3,
    S_OUT_DATA = 3'd4,
    S_OUT_BYTE = 3'd5,
    S_DONE     = 3'd6
  } io_state_e;

endpackage

// File: rtl/mix_io_ctrl_if.sv
// Command, memory-arbiter and per-unit byte-stream bundle of the MIX block-I/O engine.
interface mix_io_ctrl_if
  import mix_io_pkg::*;
#(
  parameter int UNITS  = 4,
  parameter int ADDR_W = 12
);
  localparam int UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [UNIT_W-1:0]        cmd_unit;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [UNITS-1:0]         busy;
  logic [UNITS-1:0]         err;

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [MIX_W-1:0]         mem_wdata;
  logic                     mem_gnt;
  logic [MIX_W-1:0]         mem_rdata;

  logic [UNITS-1:0]         rx_valid;
  logic [BYTE_W*UNITS-1:0]  rx_data;
  logic [UNITS-1:0]         rx_ready;
  logic [UNITS-1:0]         tx_valid;
  logic [BYTE_W-1:0]        tx_data;
  logic [UNITS-1:0]         tx_ready;

  // master is the engine; slave is the CPU/arbiter/device side
  modport master (
    input  cmd_valid, cmd_op, cmd_unit, cmd_addr,
    input  mem_gnt, mem_rdata, rx_valid, rx_data, tx_ready,
    output cmd_ready, busy, err, mem_req, mem_we, mem_addr, mem_wdata,
    output rx_ready, tx_valid, tx_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_unit, cmd_addr,
    output mem_gnt, mem_rdata, rx_valid, rx_data, tx_ready,
    input  cmd_ready, busy, err, mem_req, mem_we, mem_addr, mem_wdata,
    input  rx_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/mix_io_packer.sv
// Five-byte word shift register shared by the IN (pack) and OUT (unpack) paths.
module mix_io_packer
  import mix_io_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              shift_in,
  input  logic              shift_out,
  input  logic [WORD_W-1:0] load_word,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] byte_out,
  output logic              full,
  output logic              empty
);
  localparam logic [2:0] CNT_FULL = 3'(BYTES_PER_WORD);

  logic [WORD_W-1:0] sr_q;
  logic [2:0]        cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_FULL;
    end else if (shift_in) begin
      cnt_q <= cnt_q + 3'd1;
    end else if (shift_out) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  // Both directions shift toward the MSB: first byte lands in / leaves from bits 29:24
  always_ff @(posedge clk) begin
    if (load) begin
      sr_q <= load_word;
    end else if (shift_in) begin
      sr_q <= {sr_q[WORD_W-BYTE_W-1:0], byte_in};
    end else if (shift_out) begin
      sr_q <= {sr_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  assign word     = sr_q;
  assign byte_out = sr_q[WORD_W-1 -: BYTE_W];

  // Look-ahead flags: this cycle's shift completes (full) or drains (empty) the word
  assign full  = shift_in  && (cnt_q == CNT_FULL - 3'd1);
  assign empty = shift_out && (cnt_q == 3'd1);

endmodule

// File: rtl/mix_io_ctrl.sv
// Multi-unit MIX IN/OUT/IOC block-transfer engine between execute stage, memory arbiter and devices.
// Optional input timeout is compiled in with MIX_IO_TIMEOUT_EN.
module mix_io_ctrl
  import mix_io_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int BLOCK_WORDS = 14,
  parameter int MEM_WORDS   = 4000,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT     = 4095
) (
  input  logic          clk,
  input  logic          reset,
  mix_io_ctrl_if.master bus
);
  localparam int UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int WCNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  io_state_e         state_q, state_d;
  logic [UNIT_W-1:0] unit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [UNITS-1:0]  busy_q;
  logic [UNITS-1:0]  err_q;

  io_op_e            op;
  logic              accept;
  logic              word_end;
  logic              last_word;
  logic              tmo_hit;
  logic [BYTE_W-1:0] rx_byte;

  logic              pk_clr, pk_load, pk_shift_in, pk_shift_out;
  logic              pk_full, pk_empty;
  logic [WORD_W-1:0] pk_word;
  logic [BYTE_W-1:0] pk_byte;

  logic [UNITS-1:0]  rx_ready_c;
  logic [UNITS-1:0]  tx_valid_c;
  logic [BYTE_W-1:0] tx_data_c;
  logic              mem_req_c;
  logic              mem_we_c;
  logic [MIX_W-1:0]  mem_wdata_c;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_WORDS - 1)) ? '0 : a + 1'b1;
  endfunction

  assign op        = io_op_e'(bus.cmd_op);
  assign last_word = (wcnt_q == WCNT_W'(BLOCK_WORDS - 1));
  assign rx_byte   = bus.rx_data[unit_q*BYTE_W +: BYTE_W];

`ifdef MIX_IO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // Counts IN_BYTE cycles since the last accepted byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if ((state_q != S_IN_BYTE) || bus.rx_valid[unit_q]) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == S_IN_BYTE) && !bus.rx_valid[unit_q] &&
                   (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  mix_io_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .load      (pk_load),
    .shift_in  (pk_shift_in),
    .shift_out (pk_shift_out),
    .load_word (bus.mem_rdata[WORD_W-1:0]),
    .byte_in   (rx_byte),
    .word      (pk_word),
    .byte_out  (pk_byte),
    .full      (pk_full),
    .empty     (pk_empty)
  );

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    word_end     = 1'b0;
    pk_clr       = 1'b0;
    pk_load      = 1'b0;
    pk_shift_in  = 1'b0;
    pk_shift_out = 1'b0;
    rx_ready_c   = '0;
    tx_valid_c   = '0;
    tx_data_c    = '0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_wdata_c  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          case (op)
            IO_IN: begin
              pk_clr  = 1'b1;
              state_d = S_IN_BYTE;
            end
            IO_OUT:  state_d = S_OUT_RD;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_IN_BYTE: begin
        rx_ready_c[unit_q] = 1'b1;
        if (bus.rx_valid[unit_q]) begin
          pk_shift_in = 1'b1;
          if (pk_full) state_d = S_IN_WR;
        end else if (tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_IN_WR: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_wdata_c = {1'b0, pk_word};
        if (bus.mem_gnt) begin
          pk_clr   = 1'b1;
          word_end = 1'b1;
          state_d  = last_word ? S_DONE : S_IN_BYTE;
        end
      end
      S_OUT_RD: begin
        mem_req_c = 1'b1;
        if (bus.mem_gnt) state_d = S_OUT_DATA;
      end
      S_OUT_DATA: begin
        pk_load = 1'b1;
        state_d = S_OUT_BYTE;
      end
      S_OUT_BYTE: begin
        tx_valid_c[unit_q] = 1'b1;
        tx_data_c          = pk_byte;
        if (bus.tx_ready[unit_q]) begin
          pk_shift_out = 1'b1;
          if (pk_empty) begin
            word_end = 1'b1;
            state_d  = last_word ? S_DONE : S_OUT_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      unit_q  <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      busy_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        unit_q <= bus.cmd_unit;
        if ((op == IO_IN) || (op == IO_OUT)) begin
          busy_q[bus.cmd_unit] <= 1'b1;
          addr_q               <= bus.cmd_addr;
          wcnt_q               <= '0;
        end
        if (op == IO_IOC) err_q[bus.cmd_unit] <= 1'b0;
      end
      if (word_end) begin
        addr_q <= addr_next(addr_q);
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (tmo_hit) err_q[unit_q] <= 1'b1;
      if (state_q == S_DONE) busy_q[unit_q] <= 1'b0;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.rx_ready  = rx_ready_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;

endmodule

// File: tb/tb_mix_io_ctrl.sv
// Directed bench for mix_io_ctrl: block IN/OUT with address wrap, stalls, queued command, reset abort, IOC.
module tb_mix_io_ctrl;
  import mix_io_pkg::*;

  localparam logic [30:0] SENT = 31'h2AAA_5555;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mix_io_ctrl_if #(.UNITS(4), .ADDR_W(12)) bus ();

  mix_io_ctrl #(
    .UNITS(4), .BLOCK_WORDS(14), .MEM_WORDS(4000), .ADDR_W(12), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory/arbiter model with a backdoor preload port
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [30:0] poke_data = '0;
  logic [30:0] mem [0:4095];
  logic [11:0] rd_log [0:63];
  int          wr_n = 0;
  int          rd_n = 0;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr_n <= wr_n + 1;
      end else begin
        bus.mem_rdata      <= mem[bus.mem_addr];
        rd_log[rd_n % 64]  <= bus.mem_addr;
        rd_n <= rd_n + 1;
      end
    end
  end

  function automatic logic [30:0] pack5(input int first);
    logic [30:0] w;
    w = '0;
    for (int j = 0; j < 5; j++) w = {w[24:0], 6'((first + j) & 63)};
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [30:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] u, input logic [11:0] a, input string tag);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_unit = u; bus.cmd_addr = a;
    #1;
    check({tag, "_ready"}, 64'(bus.cmd_ready), 64'(1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Presents bytes first.. on unit u until n have been consumed; audits side signals each cycle
  task automatic feed(input int u, input int n, input int first, input logic [3:0] exp_busy,
                      input string tag);
    int b, guard, bad;
    b = 0; guard = 0; bad = 0;
    while (b < n && guard < 4000) begin
      bus.rx_valid = 4'(1 << u);
      bus.rx_data  = '0;
      bus.rx_data[6*u +: 6] = 6'((first + b) & 63);
      #1;
      if (bus.busy !== exp_busy) bad++;
      if (bus.cmd_ready !== 1'b0) bad++;
      if ((bus.rx_ready & ~4'(1 << u)) != 4'b0) bad++;
      if (bus.rx_ready[u]) b++;
      @(negedge clk);
      guard++;
    end
    bus.rx_valid = '0;
    check({tag, "_bytes"}, 64'(b), 64'(n));
    check({tag, "_side"}, 64'(bad), 64'(0));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (bus.cmd_ready !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(bus.cmd_ready), 64'(1));
  endtask

  initial begin
    int bad, n, stall_bad, other_bad, rd_base, wr0, qwait;
    logic [5:0] got [0:69];

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_unit = '0; bus.cmd_addr = '0;
    bus.mem_gnt = 1'b1; bus.rx_valid = '0; bus.rx_data = '0; bus.tx_ready = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_err",       64'(bus.err),       64'(0));
    check("rst_rx_ready",  64'(bus.rx_ready),  64'(0));
    check("rst_tx_valid",  64'(bus.tx_valid),  64'(0));
    check("rst_mem_req",   64'({bus.mem_req, bus.mem_we}), 64'(0));
    check("rst_data",      64'({bus.tx_data, bus.mem_addr, bus.mem_wdata}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // IN unit 1 at M=100, 70 bytes
    poke(12'd99, SENT);
    poke(12'd114, SENT);
    wr0 = wr_n;
    issue(2'd0, 2'd1, 12'd100, "in1");
    feed(1, 70, 1, 4'b0010, "in1");
    wait_idle("in1_idle", 20);
    check("in1_busy_after", 64'(bus.busy), 64'(0));
    check("in1_mem100", 64'(mem[100]), 64'(pack5(1)));
    check("in1_mem113", 64'(mem[113]), 64'(pack5(66)));
    bad = 0;
    for (int k = 0; k < 14; k++) if (mem[100+k] !== pack5(5*k + 1)) bad++;
    check("in1_words", 64'(bad), 64'(0));
    check("in1_wr_count", 64'(wr_n - wr0), 64'(14));
    check("in1_guard_lo", 64'(mem[99]),  64'(SENT));
    check("in1_guard_hi", 64'(mem[114]), 64'(SENT));

    // OUT unit 2 at M=3998 wrapping through 0; one word carries a set sign bit
    for (int k = 0; k < 14; k++)
      poke(12'((3998 + k) % 4000), (k == 1) ? (pack5(6) | 31'h4000_0000) : pack5(5*k + 1));
    rd_base = rd_n;
    bus.tx_ready = 4'b0100;
    issue(2'd1, 2'd2, 12'd3998, "out2");
    n = 0; bad = 0; stall_bad = 0; other_bad = 0;
    for (int g = 0; g < 3000 && n < 70; g++) begin
      if (n == 2 && stall_bad == 0 && g < 2000) begin
        bus.tx_ready = '0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (bus.tx_valid !== 4'b0100 || bus.tx_data !== 6'd3) stall_bad++;
        end
        stall_bad += 100;
        bus.tx_ready = 4'b0100;
      end
      if ((bus.tx_valid & 4'b1011) != 4'b0) other_bad++;
      if (bus.tx_valid[2] && bus.tx_ready[2]) begin
        got[n] = bus.tx_data;
        n++;
      end
      @(negedge clk);
    end
    wait_idle("out2_idle", 20);
    check("out2_count", 64'(n), 64'(70));
    for (int i = 0; i < 5; i++) check("out2_first", 64'(got[i]), 64'(i + 1));
    for (int i = 0; i < 70; i++) if (got[i] !== 6'((i + 1) & 63)) bad++;
    check("out2_bytes", 64'(bad), 64'(0));
    check("out2_stall", 64'(stall_bad), 64'(100));
    check("out2_other_tx", 64'(other_bad), 64'(0));
    check("out2_rd_count", 64'(rd_n - rd_base), 64'(14));
    check("out2_addr0", 64'(rd_log[(rd_base + 0) % 64]), 64'(3998));
    check("out2_addr1", 64'(rd_log[(rd_base + 1) % 64]), 64'(3999));
    check("out2_addr2", 64'(rd_log[(rd_base + 2) % 64]), 64'(0));
    check("out2_addr3", 64'(rd_log[(rd_base + 3) % 64]), 64'(1));
    check("out2_busy_after", 64'(bus.busy), 64'(0));
    bus.tx_ready = '0;

    // IN unit 0 running while OUT unit 3 waits on cmd_ready
    issue(2'd0, 2'd0, 12'd200, "in0");
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_unit = 2'd3; bus.cmd_addr = 12'd300;
    feed(0, 70, 1, 4'b0001, "in0");
    qwait = 0;
    while (bus.cmd_ready !== 1'b1 && qwait < 10) begin
      @(negedge clk);
      qwait++;
    end
    check("queue_wait", 64'(qwait), 64'(2));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("queue_busy3",  64'(bus.busy),      64'(4'b1000));
    check("queue_accept", 64'(bus.cmd_ready), 64'(0));
    check("in0_mem213",   64'(mem[213]),      64'(pack5(66)));
    bus.tx_ready = 4'b1000;
    wait_idle("out3_idle", 400);
    check("out3_busy_after", 64'(bus.busy), 64'(0));
    bus.tx_ready = '0;

    // Reset mid-IN after 3 bytes
    poke(12'd500, SENT);
    wr0 = wr_n;
    issue(2'd0, 2'd1, 12'd500, "rst_in");
    feed(1, 3, 1, 4'b0010, "rst_in");
    reset = 1'b1;
    #1;
    check("rstmid_busy",      64'(bus.busy),      64'(0));
    check("rstmid_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("rstmid_rx_ready",  64'(bus.rx_ready),  64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_write", 64'(wr_n - wr0), 64'(0));
    check("rstmid_mem500",   64'(mem[500]),   64'(SENT));

`ifdef MIX_IO_TIMEOUT_EN
    // 7 bytes then silence: first word lands, partial second dropped, err raised
    poke(12'd601, SENT);
    issue(2'd0, 2'd1, 12'd600, "tmo");
    feed(1, 7, 1, 4'b0010, "tmo");
    wait_idle("tmo_idle", 60);
    check("tmo_err",    64'(bus.err),  64'(4'b0010));
    check("tmo_busy",   64'(bus.busy), 64'(0));
    check("tmo_mem600", 64'(mem[600]), 64'(pack5(1)));
    check("tmo_mem601", 64'(mem[601]), 64'(SENT));
`endif

    // IOC and reserved op: accepted in place, no busy, err cleared
    issue(2'd2, 2'd1, 12'd0, "ioc");
    check("ioc_ready", 64'(bus.cmd_ready), 64'(1));
    check("ioc_busy",  64'(bus.busy),      64'(0));
    check("ioc_err",   64'(bus.err),       64'(0));
    issue(2'd3, 2'd2, 12'd0, "rsv");
    check("rsv_ready", 64'(bus.cmd_ready), 64'(1));
    check("rsv_busy",  64'(bus.busy),      64'(0));
    check("rsv_mem_req", 64'(bus.mem_req), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
